soc_bus: RTL and testbench

SOC_BUS -- requirements
Module: soc_bus

---
 rtl/soc_bus.sv | 234 +++++++++++++++++++++++
 tb/tb_soc_bus.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_bus.sv
// -----------------------------------------------------------------------------
// soc_bus
//   Core-side bus fabric for a small SoC. It decodes core load/store traffic
//   into a word-addressed RAM port and three memory-mapped registers, and it
//   owns an 8-bit transmit FIFO feeding a console consumer.
//
//   Address map:
//     0x0000_0000 .. 0x0000_3FFF  RAM (word address = address[13:2])
//     0xFFFF_0000                 TXDATA  (write pushes a byte, reads 0)
//     0xFFFF_0004                 STATUS  {24'b0, count[4:0], ovf, empty, full}
//     0xFFFF_0008                 CYCLES  (free-running counter, read only)
//     everything else             unmapped (reads 0, writes ignored)
//
//   Loads return one cycle after the address is presented for every region.
//   In the cycle following any write, readData repeats its previous value.
//
//   Optional feature macro: SOC_BUS_CYCLE_COUNTER_EN
//     defined   -> 32-bit cycle counter readable at CYCLES
//     undefined -> no counter flops, CYCLES reads 0
//
// Parameters:
//   FIFO_DEPTH      TX FIFO entries, power of two in 2..16
//   RAM_WORDS       RAM size in 32-bit words (at most 4096)
//
// Ports:
//   clk             single clock, rising edge
//   reset           asynchronous active-high reset
//   address         core byte address
//   writeData       core store data
//   writeEnable     core store strobe
//   readData        load data to the core (one cycle after address)
//   ramAddress      RAM word address (combinational)
//   ramWriteData    RAM store data (combinational)
//   ramWriteEnable  RAM store strobe (combinational, gated by reset)
//   ramReadData     RAM read data, valid one cycle after ramAddress
//   txData          head byte of the TX FIFO (registered)
//   txValid         TX FIFO holds at least one byte
//   txReady         consumer accepts txData this cycle
// -----------------------------------------------------------------------------
module soc_bus #(
    parameter int FIFO_DEPTH = 8,
    parameter int RAM_WORDS  = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    input  logic        writeEnable,
    output logic [31:0] readData,
    output logic [11:0] ramAddress,
    output logic [31:0] ramWriteData,
    output logic        ramWriteEnable,
    input  logic [31:0] ramReadData,
    output logic [7:0]  txData,
    output logic        txValid,
    input  logic        txReady
);

    localparam int          PTR_W       = $clog2(FIFO_DEPTH);
    localparam logic [31:0] RAM_LIMIT   = 32'(RAM_WORDS * 4);
    localparam logic [31:0] ADDR_TXDATA = 32'hFFFF_0000;
    localparam logic [31:0] ADDR_STATUS = 32'hFFFF_0004;
    localparam logic [31:0] ADDR_CYCLES = 32'hFFFF_0008;
    localparam logic [4:0]  DEPTH_C     = 5'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        RGN_UNMAPPED,
        RGN_RAM,
        RGN_TXDATA,
        RGN_STATUS,
        RGN_CYCLES
    } region_e;

    region_e          region_d, region_q;
    logic [31:0]      mmio_d, mmio_q;
    logic             wr_q;
    logic [31:0]      hold_q;
    logic [31:0]      status_w;
    logic [31:0]      cycles_w;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wptr_d, wptr_q;
    logic [PTR_W-1:0] rptr_d, rptr_q;
    logic [4:0]       count_d, count_q;
    logic             ovf_d, ovf_q;
    logic [7:0]       txdata_d, txdata_q;

    logic             push_req;
    logic             push_ok;
    logic             pop;
    logic             ovf_set;
    logic             ovf_clr;

    // ------------------------------------------------------------------
    // Address decode and RAM pass-through
    // ------------------------------------------------------------------
    always_comb begin
        region_d = RGN_UNMAPPED;
        if (address < RAM_LIMIT) begin
            region_d = RGN_RAM;
        end else if (address == ADDR_TXDATA) begin
            region_d = RGN_TXDATA;
        end else if (address == ADDR_STATUS) begin
            region_d = RGN_STATUS;
        end else if (address == ADDR_CYCLES) begin
            region_d = RGN_CYCLES;
        end
    end

    assign ramAddress     = address[13:2];
    assign ramWriteData   = writeData;
    assign ramWriteEnable = writeEnable && (region_d == RGN_RAM) && !reset;

    // ------------------------------------------------------------------
    // TX FIFO control
    // ------------------------------------------------------------------
    assign pop      = (count_q != 5'd0) && txReady;
    assign push_req = writeEnable && (region_d == RGN_TXDATA);
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_ok  = push_req && ((count_q < DEPTH_C) || pop);
    assign ovf_set  = push_req && !push_ok;
    assign ovf_clr  = writeEnable && (region_d == RGN_STATUS) && writeData[2];

    always_comb begin
        wptr_d  = push_ok ? wptr_q + PTR_W'(1) : wptr_q;
        rptr_d  = pop     ? rptr_q + PTR_W'(1) : rptr_q;
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 5'd1;
            2'b01:   count_d = count_q - 5'd1;
            default: count_d = count_q;
        endcase

        // Overflow set wins over a same-cycle clear.
        ovf_d = ovf_q;
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end

        // Next head byte: normally the stored entry at the new read pointer,
        // but when every old entry is gone the byte being pushed becomes the
        // head and has not reached the array yet.
        txdata_d = fifo_mem[rptr_d];
        if (push_ok && (count_q == (pop ? 5'd1 : 5'd0))) begin
            txdata_d = writeData[7:0];
        end
        if (count_d == 5'd0) begin
            txdata_d = 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !reset) begin
            fifo_mem[wptr_q] <= writeData[7:0];
        end
    end

    assign txValid = (count_q != 5'd0);
    assign txData  = txdata_q;

    // ------------------------------------------------------------------
    // Optional cycle counter
    // ------------------------------------------------------------------
`ifdef SOC_BUS_CYCLE_COUNTER_EN
    logic [31:0] cycles_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycles_q <= 32'h0;
        end else begin
            cycles_q <= cycles_q + 32'd1;
        end
    end

    assign cycles_w = cycles_q;
`else
    assign cycles_w = 32'h0;
`endif

    // ------------------------------------------------------------------
    // MMIO read data, captured on the same edge as the region
    // ------------------------------------------------------------------
    assign status_w = {24'h0, count_q, ovf_q, (count_q == 5'd0), (count_q == DEPTH_C)};

    always_comb begin
        case (region_d)
            RGN_STATUS: mmio_d = status_w;
            RGN_CYCLES: mmio_d = cycles_w;
            default:    mmio_d = 32'h0;
        endcase
    end

    // RAM data arrives directly from the RAM one cycle late; MMIO data comes
    // from mmio_q. After a write the previous load value is replayed.
    always_comb begin
        if (wr_q) begin
            readData = hold_q;
        end else if (region_q == RGN_RAM) begin
            readData = ramReadData;
        end else begin
            readData = mmio_q;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            region_q <= RGN_UNMAPPED;
            mmio_q   <= 32'h0;
            wr_q     <= 1'b0;
            hold_q   <= 32'h0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= 5'd0;
            ovf_q    <= 1'b0;
            txdata_q <= 8'h00;
        end else begin
            region_q <= region_d;
            mmio_q   <= mmio_d;
            wr_q     <= writeEnable;
            hold_q   <= readData;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            txdata_q <= txdata_d;
        end
    end

endmodule

// File: tb/tb_soc_bus.sv
// -----------------------------------------------------------------------------
// tb_soc_bus
//   Self-checking bench for soc_bus. A behavioural RAM answers the DUT's RAM
//   port; expected load data is queued when a bus cycle is driven and compared
//   when readData appears, and a byte queue models the TX FIFO contents.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_soc_bus;

    localparam int          DEPTH  = 8;
    localparam logic [31:0] A_TX   = 32'hFFFF_0000;
    localparam logic [31:0] A_ST   = 32'hFFFF_0004;
    localparam logic [31:0] A_CYC  = 32'hFFFF_0008;
    localparam logic [31:0] A_UNM  = 32'h8000_0000;
`ifdef SOC_BUS_CYCLE_COUNTER_EN
    localparam bit          CYC_EN = 1'b1;
`else
    localparam bit          CYC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic [31:0] writeData;
    logic        writeEnable;
    logic [31:0] readData;
    logic [11:0] ramAddress;
    logic [31:0] ramWriteData;
    logic        ramWriteEnable;
    logic [31:0] ramReadData;
    logic [7:0]  txData;
    logic        txValid;
    logic        txReady;

    soc_bus #(
        .FIFO_DEPTH(DEPTH),
        .RAM_WORDS (4096)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .address       (address),
        .writeData     (writeData),
        .writeEnable   (writeEnable),
        .readData      (readData),
        .ramAddress    (ramAddress),
        .ramWriteData  (ramWriteData),
        .ramWriteEnable(ramWriteEnable),
        .ramReadData   (ramReadData),
        .txData        (txData),
        .txValid       (txValid),
        .txReady       (txReady)
    );

    always #5 clk = ~clk;

    // Synchronous RAM with one cycle of read latency.
    logic [31:0] ram [4096] = '{default: 32'h0};
    always @(posedge clk) begin
        if (ramWriteEnable) begin
            ram[ramAddress] <= ramWriteData;
        end
        ramReadData <= ram[ramAddress];
    end

    // Reference count of clocks since reset release.
    int unsigned tb_cyc;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            tb_cyc <= 0;
        end else begin
            tb_cyc <= tb_cyc + 1;
        end
    end

    logic [31:0] rd_exp_q [$];
    logic [7:0]  tx_exp_q [$];
    logic [31:0] shadow [int];
    bit          ovf_m;
    logic [31:0] last_exp;
    int          n_chk  = 0;
    int          n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_status();
        int n;
        n = tx_exp_q.size();
        return {24'h0, 5'(n), ovf_m, (n == 0), (n == DEPTH)};
    endfunction

    // One bus cycle, entered between posedge+1 and posedge+3, left at posedge+1.
    task automatic bus_cycle(input logic [31:0] a, input logic [31:0] d, input logic we,
                             input logic rdy, input string tag, output logic [31:0] got);
        logic [31:0] exp_rd;
        logic        ram_hit;
        logic        pop;
        address     = a;
        writeData   = d;
        writeEnable = we;
        txReady     = rdy;
        ram_hit     = (a < 32'h4000);
        #1;
        check_eq({tag, "/ram_we"}, 32'(ramWriteEnable), 32'(we && ram_hit));
        if (we && ram_hit) begin
            check_eq({tag, "/ram_addr"}, 32'(ramAddress), 32'(a[13:2]));
            check_eq({tag, "/ram_wdata"}, ramWriteData, d);
        end
        @(negedge clk);
        check_eq({tag, "/txValid"}, 32'(txValid), 32'(tx_exp_q.size() != 0));
        if (tx_exp_q.size() != 0) begin
            check_eq({tag, "/txData"}, 32'(txData), 32'(tx_exp_q[0]));
        end
        if (we) begin
            exp_rd = last_exp;
        end else if (ram_hit) begin
            exp_rd = shadow.exists(int'(a[13:2])) ? shadow[int'(a[13:2])] : 32'h0;
        end else if (a == A_ST) begin
            exp_rd = model_status();
        end else if (a == A_CYC) begin
            exp_rd = CYC_EN ? tb_cyc : 32'h0;
        end else begin
            exp_rd = 32'h0;
        end
        rd_exp_q.push_back(exp_rd);
        pop = (tx_exp_q.size() != 0) && rdy;
        if (pop) begin
            tx_exp_q.delete(0);
        end
        if (we && (a == A_TX)) begin
            if (tx_exp_q.size() < DEPTH) begin
                tx_exp_q.push_back(d[7:0]);
            end else begin
                ovf_m = 1'b1;
            end
        end else if (we && (a == A_ST) && d[2]) begin
            ovf_m = 1'b0;
        end
        if (we && ram_hit) begin
            shadow[int'(a[13:2])] = d;
        end
        @(posedge clk);
        #1;
        exp_rd = rd_exp_q.pop_front();
        got    = readData;
        check_eq({tag, "/readData"}, got, exp_rd);
        last_exp = exp_rd;
    endtask

    // Reset pulse spanning one clock edge, entered and left at posedge+1/+2.
    task automatic pulse_reset(input string tag);
        address     = 32'h0000_0020;
        writeData   = 32'hBAD0_BAD0;
        writeEnable = 1'b1;
        txReady     = 1'b0;
        reset       = 1'b1;
        #1;
        check_eq({tag, "/readData"}, readData, 32'h0);
        check_eq({tag, "/txValid"}, 32'(txValid), 32'h0);
        check_eq({tag, "/txData"}, 32'(txData), 32'h0);
        check_eq({tag, "/ram_we_gated"}, 32'(ramWriteEnable), 32'h0);
        tx_exp_q.delete();
        ovf_m    = 1'b0;
        last_exp = 32'h0;
        @(posedge clk);
        #1;
        writeEnable = 1'b0;
        address     = A_UNM;
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        logic [31:0] c1;
        logic [31:0] c2;
        reset       = 1'b1;
        address     = 32'h0;
        writeData   = 32'h0;
        writeEnable = 1'b0;
        txReady     = 1'b0;
        ovf_m       = 1'b0;
        last_exp    = 32'h0;

        @(posedge clk);
        #1;
        check_eq("rst/readData", readData, 32'h0);
        check_eq("rst/txValid", 32'(txValid), 32'h0);
        check_eq("rst/txData", 32'(txData), 32'h0);
        #1;
        reset = 1'b0;

        // RAM store/load, boundaries and readData hold after writes
        bus_cycle(32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 1'b0, "ram_wr", got);
        bus_cycle(32'h0000_0010, 32'h0, 1'b0, 1'b0, "ram_rd", got);
        check_eq("ram_rd_value", got, 32'hDEAD_BEEF);
        bus_cycle(32'h0000_0000, 32'hCAFE_0001, 1'b1, 1'b0, "ram_wr0", got);
        bus_cycle(32'h0000_3FFC, 32'h0BAD_F00D, 1'b1, 1'b0, "ram_wr_top", got);
        bus_cycle(32'h0000_0200, 32'h1234_5678, 1'b1, 1'b0, "ram_wr_hold", got);
        check_eq("hold_value", got, 32'hDEAD_BEEF);
        bus_cycle(32'h0000_3FFC, 32'h0, 1'b0, 1'b0, "ram_rd_top", got);
        bus_cycle(32'h0000_0000, 32'h0, 1'b0, 1'b0, "ram_rd0", got);
        bus_cycle(32'h0000_4000, 32'h0, 1'b0, 1'b0, "rd_past_ram", got);
        bus_cycle(32'h0000_0200, 32'h0, 1'b0, 1'b0, "ram_rd_200", got);
        bus_cycle(32'h0000_0014, 32'h0, 1'b0, 1'b0, "ram_rd_blank", got);

        // Unmapped and TXDATA reads
        bus_cycle(A_UNM, 32'hFFFF_FFFF, 1'b1, 1'b0, "unm_wr", got);
        bus_cycle(A_UNM, 32'h0, 1'b0, 1'b0, "unm_rd", got);
        bus_cycle(A_TX, 32'h0, 1'b0, 1'b0, "txdata_rd", got);

        // Fill the FIFO with the consumer stalled, then overflow it
        for (int i = 0; i < DEPTH; i++) begin
            bus_cycle(A_TX, 32'h41 + i, 1'b1, 1'b0, "tx_fill", got);
        end
        bus_cycle(A_TX, 32'h5A, 1'b1, 1'b0, "tx_ovf", got);
        bus_cycle(A_ST, 32'h0, 1'b0, 1'b0, "st_full_ovf", got);
        // count 8 -> 0x40, overflow -> 0x04, full -> 0x01
        check_eq("st_full_ovf_value", got, 32'h45);

        // Clear the sticky overflow
        bus_cycle(A_ST, 32'h4, 1'b1, 1'b0, "st_clr", got);
        bus_cycle(A_ST, 32'h0, 1'b0, 1'b0, "st_after_clr", got);
        check_eq("st_after_clr_value", got, 32'h41);

        // Push into a full FIFO while the head is taken
        bus_cycle(A_TX, 32'h49, 1'b1, 1'b1, "tx_push_pop", got);
        check_eq("tx_next_head", 32'(txData), 32'h42);
        bus_cycle(A_ST, 32'h0, 1'b0, 1'b0, "st_after_pushpop", got);
        check_eq("st_after_pushpop_value", got, 32'h41);

        // Drain everything
        for (int i = 0; i < DEPTH; i++) begin
            bus_cycle(A_TX, 32'h0, 1'b0, 1'b1, "drain", got);
        end
        bus_cycle(A_ST, 32'h0, 1'b0, 1'b1, "st_empty", got);
        check_eq("st_empty_value", got, 32'h02);

        // Partial FIFO with push and pop in the same cycle
        bus_cycle(A_TX, 32'h61, 1'b1, 1'b0, "part_push", got);
        bus_cycle(A_TX, 32'h62, 1'b1, 1'b1, "part_pushpop", got);
        bus_cycle(A_TX, 32'h63, 1'b1, 1'b1, "part_pushpop2", got);
        bus_cycle(A_ST, 32'h0, 1'b0, 1'b1, "part_st", got);
        bus_cycle(A_ST, 32'h0, 1'b0, 1'b1, "part_st2", got);

        // Reset while bytes are queued
        for (int i = 0; i < 3; i++) begin
            bus_cycle(A_TX, 32'h71 + i, 1'b1, 1'b0, "pre_rst_push", got);
        end
        pulse_reset("mid_rst");
        bus_cycle(A_ST, 32'h0, 1'b0, 1'b1, "st_after_rst", got);
        check_eq("st_after_rst_value", got, 32'h02);
        bus_cycle(A_UNM, 32'h0, 1'b0, 1'b1, "idle_after_rst", got);
        bus_cycle(32'h0000_0010, 32'h0, 1'b0, 1'b1, "ram_after_rst", got);

        // Cycle counter: two reads ten clocks apart, writes ignored
        bus_cycle(A_CYC, 32'h0, 1'b0, 1'b0, "cyc1", c1);
        for (int i = 0; i < 9; i++) begin
            bus_cycle(A_UNM, 32'h0, 1'b0, 1'b0, "cyc_gap", got);
        end
        bus_cycle(A_CYC, 32'h0, 1'b0, 1'b0, "cyc2", c2);
        check_eq("cyc_diff", c2 - c1, CYC_EN ? 32'd10 : 32'd0);
        bus_cycle(A_CYC, 32'h1234_0000, 1'b1, 1'b0, "cyc_wr", got);
        bus_cycle(A_CYC, 32'h0, 1'b0, 1'b0, "cyc3", got);
        bus_cycle(A_UNM, 32'h0, 1'b0, 1'b0, "unm_final", got);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
